// File: rtl/pwm_meter_pkg.sv
// pwm_meter_pkg: FSM state type and default window width shared by the pwm_duty_meter files
package pwm_meter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEASURE = 2'd2, DONE = 2'd3} meter_state_t;
  localparam int PWM_METER_WIN_W_DEF = 8;
endpackage

// File: rtl/pwm_duty_meter_if.sv
// pwm_duty_meter_if: control (en, cont, start) and result (duty, rise_cnt, valid, busy, stuck_hi, stuck_lo) bundle; master drives control, slave is the meter
interface pwm_duty_meter_if import pwm_meter_pkg::*; #(
  parameter int WIN_W = PWM_METER_WIN_W_DEF
) ();
  logic en, cont, start;
  logic [WIN_W-1:0] duty, rise_cnt;
  logic valid, busy, stuck_hi, stuck_lo;
  modport master (output en, cont, start, input duty, rise_cnt, valid, busy, stuck_hi, stuck_lo);
  modport slave (input en, cont, start, output duty, rise_cnt, valid, busy, stuck_hi, stuck_lo);
endinterface

// File: rtl/pwm_in_cond.sv
// pwm_in_cond: clk, rst, async pwm_in -> SYNC_STAGES synchronizer, optional 3-sample glitch filter (PWM_METER_GLITCH_FILTER_EN), outputs level s and rise
module pwm_in_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic s_d;
`ifdef PWM_METER_GLITCH_FILTER_EN
  logic [1:0] h;
  always_ff @(posedge clk)
    if (rst) h <= '0;
    else h <= {h[0], sync[SYNC_STAGES-1]};
  always_comb s = (h == {2{sync[SYNC_STAGES-1]}}) ? sync[SYNC_STAGES-1] : s_d;
`else
  always_comb s = sync[SYNC_STAGES-1];
`endif
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      s_d <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d <= s;
    end
  always_comb rise = s & ~s_d;
endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: PWM duty/edge meter; ports clk, rst, pwm_in, bus (pwm_duty_meter_if.slave); glitch filter via PWM_METER_GLITCH_FILTER_EN
module pwm_duty_meter import pwm_meter_pkg::*; #(
  parameter int WIN_W = PWM_METER_WIN_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  input logic pwm_in,
  pwm_duty_meter_if.slave bus
);
  meter_state_t state, nxt;
  logic s, rise, last;
  logic [WIN_W-1:0] cnt;
  logic [WIN_W:0] hi, re, hi_nx, re_nx;
  pwm_in_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .s(s), .rise(rise)
  );
  always_comb begin
    last = &cnt;
    hi_nx = hi + {{WIN_W{1'b0}}, s};
    re_nx = re + {{WIN_W{1'b0}}, rise};
    nxt = !bus.en ? IDLE :
          state == IDLE ? ((bus.start | bus.cont) ? ARM : IDLE) :
          state == ARM ? (rise ? MEASURE : last ? DONE : ARM) :
          state == MEASURE ? (last ? DONE : MEASURE) :
          (bus.cont ? ARM : IDLE);
    bus.busy = state == ARM || state == MEASURE;
    bus.valid = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      re <= '0;
      bus.duty <= '0;
      bus.rise_cnt <= '0;
      bus.stuck_hi <= 1'b0;
      bus.stuck_lo <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == ARM && nxt == MEASURE) ? WIN_W'(1) :
             (state == nxt && state != IDLE) ? cnt + 1'b1 : '0;
      hi <= state == MEASURE ? hi_nx : (WIN_W+1)'(1);
      re <= state == MEASURE ? re_nx : (WIN_W+1)'(1);
      if (nxt == DONE) begin
        bus.duty <= state == ARM ? {WIN_W{s}} : hi_nx[WIN_W] ? '1 : hi_nx[WIN_W-1:0];
        bus.rise_cnt <= state == ARM ? '0 : re_nx[WIN_W] ? '1 : re_nx[WIN_W-1:0];
        bus.stuck_hi <= state == ARM && s;
        bus.stuck_lo <= state == ARM && !s;
      end
    end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: randomized self-checking bench for pwm_duty_meter against a window-counting model
module tb_pwm_duty_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_in;
  int n_chk = 0, n_fail = 0;
  int mode = 0, per = 2, hi_len = 1, ph = 0;
  int cyc_now = 0;
  pwm_duty_meter_if #(.WIN_W(8)) bus ();
  pwm_duty_meter #(.WIN_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .bus(bus)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;
  initial begin
    pwm_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pwm_in = (mode == 2) ? (ph < hi_len) : (mode == 1);
      ph = (ph + 1 >= per) ? 0 : ph + 1;
    end
  end
  function automatic void model(input int p, input int h, output int d, output int r);
    d = 0;
    r = 0;
    for (int i = 0; i < 256; i++) begin
      if (i % p < h) d++;
      if (i % p == 0) r++;
    end
    if (d > 255) d = 255;
    if (r > 255) r = 255;
  endfunction
  task automatic set_wave(input int m, input int p, input int h);
    mode = m;
    per = p;
    hi_len = h;
    ph = 0;
    repeat (10) @(negedge clk);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_valid(output int c);
    c = 0;
    while (!bus.valid && c < 1000) begin
      @(negedge clk);
      c++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.cont = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if ({bus.duty, bus.rise_cnt, bus.valid, bus.busy, bus.stuck_hi, bus.stuck_lo} !== 20'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", {bus.duty, bus.rise_cnt, bus.valid, bus.busy, bus.stuck_hi, bus.stuck_lo}); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus.valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset got %b want 00", {bus.valid, bus.busy}); end
  endtask
  task automatic test_matched();
    int d, r, c, n;
    set_wave(2, 256, 170);
    model(256, 170, d, r);
    pulse_start();
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b want 1", bus.busy); end
    wait_valid(c);
    n_chk++; if (c >= 1000) begin n_fail++; $display("FAIL matched_timeout got %0d cycles want <1000", c); end
    n_chk++; if (bus.duty !== 8'(d)) begin n_fail++; $display("FAIL matched_duty got %0d want %0d", bus.duty, d); end
    n_chk++; if (bus.rise_cnt !== 8'(r)) begin n_fail++; $display("FAIL matched_rise got %0d want %0d", bus.rise_cnt, r); end
    n_chk++; if ({bus.stuck_hi, bus.stuck_lo} !== 2'b00) begin n_fail++; $display("FAIL matched_stuck got %b want 00", {bus.stuck_hi, bus.stuck_lo}); end
    @(negedge clk);
    n = 0;
    repeat (400) begin
      if (bus.valid) n++;
      @(negedge clk);
    end
    n_chk++; if (n != 0) begin n_fail++; $display("FAIL single_shot_extra_valid got %0d want 0", n); end
  endtask
  task automatic test_random();
    int p, h, d, r, c;
    for (int k = 0; k < 5; k++) begin
      p = int'($urandom_range(256, 2));
      h = int'($urandom_range(p - 1, 1));
      set_wave(2, p, h);
      model(p, h, d, r);
      pulse_start();
      wait_valid(c);
      n_chk++; if (c >= 1000) begin n_fail++; $display("FAIL random_timeout p=%0d h=%0d got %0d want <1000", p, h, c); end
      n_chk++; if (bus.duty !== 8'(d)) begin n_fail++; $display("FAIL random_duty p=%0d h=%0d got %0d want %0d", p, h, bus.duty, d); end
      n_chk++; if (bus.rise_cnt !== 8'(r)) begin n_fail++; $display("FAIL random_rise p=%0d h=%0d got %0d want %0d", p, h, bus.rise_cnt, r); end
      @(negedge clk);
    end
  endtask
  task automatic test_fast_cont();
    int d, r, c, t0;
    t0 = 0;
    set_wave(2, 16, 4);
    model(16, 4, d, r);
    bus.cont = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(c);
      n_chk++; if (c >= 1000) begin n_fail++; $display("FAIL cont_timeout got %0d want <1000", c); end
      n_chk++; if (bus.duty !== 8'(d)) begin n_fail++; $display("FAIL cont_duty got %0d want %0d", bus.duty, d); end
      n_chk++; if (bus.rise_cnt !== 8'(r)) begin n_fail++; $display("FAIL cont_rise got %0d want %0d", bus.rise_cnt, r); end
      if (k > 0) begin
        n_chk++; if (cyc_now - t0 < 257 || cyc_now - t0 > 272) begin n_fail++; $display("FAIL cont_spacing got %0d want 257..272", cyc_now - t0); end
      end
      t0 = cyc_now;
      @(negedge clk);
    end
    bus.cont = 1'b0;
    wait_valid(c);
    repeat (2) @(negedge clk);
    n_chk++; if ({bus.busy, bus.valid} !== 2'b00) begin n_fail++; $display("FAIL cont_drop_idle got %b want 00", {bus.busy, bus.valid}); end
  endtask
  task automatic test_stuck();
    int c;
    set_wave(0, 2, 1);
    pulse_start();
    wait_valid(c);
    n_chk++; if (c != 256) begin n_fail++; $display("FAIL stuck_lo_latency got %0d want 256", c); end
    n_chk++; if ({bus.duty, bus.rise_cnt} !== 16'd0) begin n_fail++; $display("FAIL stuck_lo_result got %0d/%0d want 0/0", bus.duty, bus.rise_cnt); end
    n_chk++; if ({bus.stuck_hi, bus.stuck_lo} !== 2'b01) begin n_fail++; $display("FAIL stuck_lo_flags got %b want 01", {bus.stuck_hi, bus.stuck_lo}); end
    @(negedge clk);
    set_wave(1, 2, 1);
    pulse_start();
    wait_valid(c);
    n_chk++; if (c != 256) begin n_fail++; $display("FAIL stuck_hi_latency got %0d want 256", c); end
    n_chk++; if (bus.duty !== 8'd255 || bus.rise_cnt !== 8'd0) begin n_fail++; $display("FAIL stuck_hi_result got %0d/%0d want 255/0", bus.duty, bus.rise_cnt); end
    n_chk++; if ({bus.stuck_hi, bus.stuck_lo} !== 2'b10) begin n_fail++; $display("FAIL stuck_hi_flags got %b want 10", {bus.stuck_hi, bus.stuck_lo}); end
    @(negedge clk);
  endtask
  task automatic test_abort();
    int n;
    set_wave(2, 32, 8);
    pulse_start();
    repeat (150) @(negedge clk);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b want 1", bus.busy); end
    bus.en = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after got %b want 0", bus.busy); end
    n = 0;
    repeat (300) begin
      if (bus.valid) n++;
      @(negedge clk);
    end
    n_chk++; if (n != 0) begin n_fail++; $display("FAIL abort_valid got %0d want 0", n); end
    n_chk++; if (bus.duty !== 8'd255 || {bus.stuck_hi, bus.stuck_lo} !== 2'b10) begin n_fail++; $display("FAIL abort_results_kept got %0d/%b want 255/10", bus.duty, {bus.stuck_hi, bus.stuck_lo}); end
    bus.en = 1'b1;
    @(negedge clk);
    pulse_start();
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus.duty, bus.rise_cnt, bus.valid, bus.busy, bus.stuck_hi, bus.stuck_lo} !== 20'd0) begin n_fail++; $display("FAIL rst_mid_outputs got %h want 0", {bus.duty, bus.rise_cnt, bus.valid, bus.busy, bus.stuck_hi, bus.stuck_lo}); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_glitch();
    int d, r, c;
    set_wave(2, 40, 1);
    model(40, 1, d, r);
    pulse_start();
    wait_valid(c);
    n_chk++; if (c >= 1000) begin n_fail++; $display("FAIL glitch_timeout got %0d want <1000", c); end
`ifdef PWM_METER_GLITCH_FILTER_EN
    n_chk++; if ({bus.stuck_hi, bus.stuck_lo} !== 2'b01 || bus.duty !== 8'd0) begin n_fail++; $display("FAIL glitch_filtered got %b/%0d want 01/0", {bus.stuck_hi, bus.stuck_lo}, bus.duty); end
`else
    n_chk++; if (bus.rise_cnt !== 8'(r) || bus.rise_cnt < 8'd1) begin n_fail++; $display("FAIL glitch_rise got %0d want %0d", bus.rise_cnt, r); end
    n_chk++; if (bus.duty !== 8'(d)) begin n_fail++; $display("FAIL glitch_duty got %0d want %0d", bus.duty, d); end
`endif
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_matched();
    test_random();
    test_fast_cont();
    test_stuck();
    test_abort();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

Measures the duty cycle and edge rate of an external PWM waveform. It is the receive-side counterpart of the playground's 8-bit PWM generator: a generator programmed with duty D over a 256-clock period reads back as D. The block sits behind the mode mux as a capture peripheral. It samples one asynchronous pin and reports a registered result with a one-cycle valid strobe.

## Interface
- `WIN_W`, default 8: log2 of the measurement window in clocks. Also the width of `duty` and `rise_cnt`.
- `SYNC_STAGES`, default 2: number of flops in the input synchronizer. Minimum 2.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: block enable. Low forces IDLE and aborts any measurement in progress.
- `cont` in 1: continuous mode. Re-arms automatically after each result.
- `start` in 1: single-shot request pulse. Sampled only in IDLE.
- `pwm_in` in 1: asynchronous PWM input.
- `duty` out WIN_W: number of high samples in the window, saturated at all-ones.
- `rise_cnt` out WIN_W: rising edges seen in the window (first edge included), saturating.
- `valid` out 1: one-cycle strobe. Results are updated in the same cycle.
- `busy` out 1: high in ARM and MEASURE.
- `stuck_hi` out 1: ARM timed out with the input high.
- `stuck_lo` out 1: ARM timed out with the input low.

## Operation
- Input path: `pwm_in` passes through SYNC_STAGES flops, then the optional filter, giving `s`. A rising edge `rise` = `s & ~s_d`.
- FSM states: IDLE, ARM, MEASURE, DONE.
- **IDLE**
  - `en & (start | cont)` → ARM.
  - Clears the timeout counter.
- **ARM**: waits for `rise`.
  - On `rise` → MEASURE. That cycle is window sample 0.
  - Otherwise the timeout counter counts up. After 2^WIN_W cycles without an edge → DONE with a timeout result:
    - `s`=1: `duty`=all-ones, `stuck_hi`=1.
    - `s`=0: `duty`=0, `stuck_lo`=1.
    - Either case: `rise_cnt`=0.
- **MEASURE**: exactly 2^WIN_W samples, starting with the edge cycle.
  - `hi_cnt` (WIN_W+1 bits) increments when `s`=1.
  - `re_cnt` increments on `rise`.
  - After the last sample → DONE.
- **DONE**: one cycle.
  - `duty` = `min(hi_cnt, 2^WIN_W−1)`.
  - `rise_cnt` = `re_cnt`, saturating.
  - `stuck_*` = 0 for a normal measurement.
  - `valid`=1.
  - Next state: ARM if `en & cont`, otherwise IDLE.
- Result registers hold their value until the next DONE.
- `en` deasserted in any state → IDLE next cycle. No `valid` is issued, and result registers are kept.
- `start` outside IDLE is ignored. `cont` dropping mid-measurement completes the current window and then returns to IDLE.
- A `rise` in the first ARM cycle is accepted. A timeout and an edge in the same cycle resolve to the edge.

## Timing
- Reset values:
  - `duty`=0, `rise_cnt`=0, `valid`=0, `busy`=0, `stuck_hi`=0, `stuck_lo`=0.
  - FSM in IDLE.
  - Synchronizer flops cleared to 0.
- Pin-to-`s` latency: SYNC_STAGES cycles, plus 2 with the filter.
- If `rise` is seen in cycle E, `valid` asserts in cycle E+2^WIN_W. `busy` is low in that DONE cycle.
- In continuous mode the block is back in ARM at E+2^WIN_W+1. At most one input period is lost between windows.
- `start` accepted in cycle T: `busy` goes high at T+1.
- Reset mid-measurement: all outputs return to their reset values on the next edge.

## Configuration
- `PWM_METER_GLITCH_FILTER_EN` defined:
  - A 3-sample agreement filter follows the synchronizer. `s` changes only after 3 consecutive equal synchronized samples.
  - Adds 2 cycles of latency and rejects pulses shorter than 3 clocks.
- Undefined: `s` is the synchronizer output directly. A 1-clock pulse is counted.

## Structure
- `pwm_meter_pkg` holds:
  - the `meter_state_t` enum (IDLE, ARM, MEASURE, DONE);
  - the `PWM_METER_WIN_W_DEF` = 8 constant.
- Sub-module `pwm_in_cond` contains the synchronizer, the optional filter and the edge detector. It outputs `s` and `rise`.
- The top level holds the FSM, counters and result registers.

## Test plan
All scenarios use WIN_W=8, the filter off, and a 20 ns clock.
- **Matched generator**: source with period 256 and duty 170, single-shot `start` → `valid` once; `duty`=170, `rise_cnt`=1, `stuck_*`=0.
- **Fast PWM**: period 16, 4 clocks high, `cont`=1 → every result has `duty`=64 and `rise_cnt`=16. Successive `valid` pulses are between 257 and 272 cycles apart.
- **Stuck input**:
  - `pwm_in`=0 with `start` → `valid` 256 cycles after ARM entry; `duty`=0, `stuck_lo`=1.
  - `pwm_in`=1 → `duty`=255, `stuck_hi`=1, `rise_cnt`=0.
- **Abort**: `en` dropped 100 cycles into MEASURE → no `valid`, `busy`=0 next cycle, previous results unchanged. `rst` mid-window → all outputs 0.
- **Glitch** (filter compiled in): 1-clock pulses on a low line → ARM times out with `stuck_lo`=1. With the filter compiled out → `rise_cnt`≥1.
